// File: rtl/core_pkg.sv
// Shared core definitions: register index width, ValidReg bit positions,
// instruction class and hazard cause encodings, shadow slot payload.
package core_pkg;

  localparam int unsigned XLEN_REGS = 32;
  localparam int unsigned REG_W     = $clog2(XLEN_REGS);
  localparam int unsigned CNT_W     = 32;

  // ID_ValidReg bit positions
  localparam int unsigned VR_RD  = 0;
  localparam int unsigned VR_RS1 = 1;
  localparam int unsigned VR_RS2 = 2;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] perf_cnt_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_DIV  = 2'd2,
    CLS_RSVD = 2'd3
  } id_class_e;

  typedef enum logic [1:0] {
    HC_NONE       = 2'd0,
    HC_LOAD_USE   = 2'd1,
    HC_DIV_DEP    = 2'd2,
    HC_DIV_STRUCT = 2'd3
  } hazard_cause_e;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     wr;
    logic     is_load;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface. The pipeline side is the master, the
// scoreboard is the slave. HAZARD_PERF_EN adds the stall counters.
interface hazard_scoreboard_if;
  import core_pkg::*;

  logic       ID_valid;
  reg_idx_t   ID_rs1;
  reg_idx_t   ID_rs2;
  reg_idx_t   ID_rd;
  logic [2:0] ID_ValidReg;
  logic [1:0] ID_class;
  logic       EX_ready;
  logic       flush;
  logic       div_done;

  logic       stall_id;
  logic       bubble_ex;
  logic       div_busy;
  logic [1:0] hazard_cause;

`ifdef HAZARD_PERF_EN
  perf_cnt_t  perf_loaduse_cnt;
  perf_cnt_t  perf_div_cnt;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rd, ID_ValidReg, ID_class,
    output EX_ready, flush, div_done,
    input  stall_id, bubble_ex, div_busy, hazard_cause,
    input  perf_loaduse_cnt, perf_div_cnt
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rd, ID_ValidReg, ID_class,
    input  EX_ready, flush, div_done,
    output stall_id, bubble_ex, div_busy, hazard_cause,
    output perf_loaduse_cnt, perf_div_cnt
  );
`else
  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rd, ID_ValidReg, ID_class,
    output EX_ready, flush, div_done,
    input  stall_id, bubble_ex, div_busy, hazard_cause
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rd, ID_ValidReg, ID_class,
    input  EX_ready, flush, div_done,
    output stall_id, bubble_ex, div_busy, hazard_cause
  );
`endif

endinterface

// File: rtl/hazard_slot.sv
// Shadow pipeline slot: holds one in-flight instruction's destination
// info and flags source registers that would read a not-yet-forwardable
// load result.
module hazard_slot
  import core_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  slot_t    slot_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  output slot_t    slot_o,
  output logic     rs1_load_hit_o,
  output logic     rs2_load_hit_o
);

  slot_t slot_q;
  slot_t slot_d;
  logic  load_wr_c;

  // Next-state: advance when told to, otherwise hold
  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d = slot_i;
    end
  end

  // Slot register
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // rd match against a pending load write; x0 never matches
  always_comb begin
    load_wr_c      = slot_q.valid & slot_q.wr & slot_q.is_load;
    rs1_load_hit_o = load_wr_c & (rs1_i != '0) & (rs1_i == slot_q.rd);
    rs2_load_hit_o = load_wr_c & (rs2_i != '0) & (rs2_i == slot_q.rd);
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight loads (EX/MEM shadow
// slots) and one outstanding divider result, stalls ID and bubbles EX
// while a source operand cannot be forwarded yet.
// Optional: define HAZARD_PERF_EN for load-use / divider stall counters.
module hazard_scoreboard
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  logic          gate_c;
  logic          use_rs1_c;
  logic          use_rs2_c;
  logic          div_open_c;
  logic          load_use_c;
  logic          div_dep_c;
  logic          div_struct_c;
  logic          stall_c;
  logic          issue_c;
  hazard_cause_e cause_c;

  logic          ex_hit1;
  logic          ex_hit2;
  logic          mem_hit1;
  logic          mem_hit2;
  slot_t         ex_slot_d;
  slot_t         ex_slot;
  slot_t         mem_slot_unused;

  logic          div_pending_q;
  logic          div_pending_d;
  reg_idx_t      div_rd_q;
  reg_idx_t      div_rd_d;

  // Hazard detection, cause priority and issue decision
  always_comb begin
    gate_c       = sb.ID_valid & ~sb.flush;
    use_rs1_c    = sb.ID_ValidReg[VR_RS1];
    use_rs2_c    = sb.ID_ValidReg[VR_RS2];
    // a divide finishing this cycle is forwarded from WB, so it no longer blocks
    div_open_c   = div_pending_q & ~sb.div_done;

    load_use_c   = gate_c & ((use_rs1_c & (ex_hit1 | mem_hit1)) |
                             (use_rs2_c & (ex_hit2 | mem_hit2)));
    div_dep_c    = gate_c & div_open_c &
                   ((use_rs1_c & (sb.ID_rs1 == div_rd_q)) |
                    (use_rs2_c & (sb.ID_rs2 == div_rd_q)) |
                    (sb.ID_ValidReg[VR_RD] & (sb.ID_rd == div_rd_q)));
    div_struct_c = gate_c & div_open_c & (sb.ID_class == CLS_DIV);

    stall_c      = load_use_c | div_dep_c | div_struct_c;
    issue_c      = sb.ID_valid & ~stall_c & sb.EX_ready & ~sb.flush;

    cause_c      = HC_NONE;
    if (load_use_c) begin
      cause_c = HC_LOAD_USE;
    end else if (div_dep_c) begin
      cause_c = HC_DIV_DEP;
    end else if (div_struct_c) begin
      cause_c = HC_DIV_STRUCT;
    end
  end

  // EX slot input: the issuing instruction, or empty (bubble/flush/not issued)
  always_comb begin
    ex_slot_d = '0;
    if (issue_c) begin
      ex_slot_d.valid   = 1'b1;
      ex_slot_d.rd      = sb.ID_rd;
      ex_slot_d.wr      = sb.ID_ValidReg[VR_RD];
      ex_slot_d.is_load = (sb.ID_class == CLS_LOAD);
    end
  end

  hazard_slot u_ex_slot (
    .clk            (clk),
    .rst            (rst),
    .load_i         (1'b1),
    .slot_i         (ex_slot_d),
    .rs1_i          (sb.ID_rs1),
    .rs2_i          (sb.ID_rs2),
    .slot_o         (ex_slot),
    .rs1_load_hit_o (ex_hit1),
    .rs2_load_hit_o (ex_hit2)
  );

  // MEM is the last tracked stage; its payload is not consumed further
  hazard_slot u_mem_slot (
    .clk            (clk),
    .rst            (rst),
    .load_i         (sb.EX_ready),
    .slot_i         (ex_slot),
    .rs1_i          (sb.ID_rs1),
    .rs2_i          (sb.ID_rs2),
    .slot_o         (mem_slot_unused),
    .rs1_load_hit_o (mem_hit1),
    .rs2_load_hit_o (mem_hit2)
  );

  // Divider tracking: done clears, a new DIV issue (rd != x0) re-arms
  always_comb begin
    div_pending_d = div_pending_q;
    div_rd_d      = div_rd_q;
    if (sb.div_done) begin
      div_pending_d = 1'b0;
    end
    if (issue_c && (sb.ID_class == CLS_DIV) && (sb.ID_rd != '0)) begin
      div_pending_d = 1'b1;
      div_rd_d      = sb.ID_rd;
    end
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_pending_q <= 1'b0;
      div_rd_q      <= '0;
    end else begin
      div_pending_q <= div_pending_d;
      div_rd_q      <= div_rd_d;
    end
  end

  // Combinational outputs to ID/EX control
  always_comb begin
    sb.stall_id     = stall_c;
    sb.bubble_ex    = stall_c;
    sb.div_busy     = div_pending_q;
    sb.hazard_cause = cause_c;
  end

`ifdef HAZARD_PERF_EN
  perf_cnt_t lu_cnt_q;
  perf_cnt_t lu_cnt_d;
  perf_cnt_t div_cnt_q;
  perf_cnt_t div_cnt_d;

  // Saturating stall counters; structural stalls count as divider stalls
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    div_cnt_d = div_cnt_q;
    if (stall_c && (cause_c == HC_LOAD_USE) && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + perf_cnt_t'(1);
    end
    if (stall_c && (cause_c != HC_LOAD_USE) && (div_cnt_q != '1)) begin
      div_cnt_d = div_cnt_q + perf_cnt_t'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      div_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign sb.perf_loaduse_cnt = lu_cnt_q;
  assign sb.perf_div_cnt     = div_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  // Reference model: list of loads still in EX (stage 1) or MEM (stage 2)
  typedef struct {
    int rd;
    int stage;
  } ld_t;

  ld_t ld_q[$];
  bit  m_pend;
  int  m_rd;
  int  m_lu_cnt;
  int  m_dv_cnt;
  int  exp_stall;
  int  exp_cause;
  int  n_checks;
  int  n_pass;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Expected combinational outputs from model state and current ID inputs
  function automatic void model_eval();
    bit g, u1, u2, lu, dep, st, open;
    g    = bus.ID_valid && !bus.flush;
    u1   = bus.ID_ValidReg[1] && (bus.ID_rs1 != 0);
    u2   = bus.ID_ValidReg[2] && (bus.ID_rs2 != 0);
    open = m_pend && !bus.div_done;
    lu = 0; dep = 0; st = 0;
    foreach (ld_q[i]) begin
      if ((u1 && ld_q[i].rd == int'(bus.ID_rs1)) || (u2 && ld_q[i].rd == int'(bus.ID_rs2)))
        lu = 1;
    end
    if (open && ((u1 && int'(bus.ID_rs1) == m_rd) || (u2 && int'(bus.ID_rs2) == m_rd) ||
                 (bus.ID_ValidReg[0] && int'(bus.ID_rd) == m_rd)))
      dep = 1;
    if (open && bus.ID_class == 2'd2) st = 1;
    exp_stall = (g && (lu || dep || st)) ? 1 : 0;
    exp_cause = !g ? 0 : lu ? 1 : dep ? 2 : st ? 3 : 0;
  endfunction

  // Advance model at the clock edge
  function automatic void model_commit();
    ld_t nq[$];
    bit  issue;
    if (rst) begin
      ld_q.delete();
      m_pend = 0; m_rd = 0; m_lu_cnt = 0; m_dv_cnt = 0;
      return;
    end
    issue = bus.ID_valid && (exp_stall == 0) && bus.EX_ready && !bus.flush;
    if (exp_stall != 0) begin
      if (exp_cause == 1) m_lu_cnt++;
      else m_dv_cnt++;
    end
    foreach (ld_q[i]) begin
      if (bus.EX_ready && ld_q[i].stage == 1) nq.push_back('{rd: ld_q[i].rd, stage: 2});
      if (!bus.EX_ready && ld_q[i].stage == 2) nq.push_back(ld_q[i]);
    end
    ld_q = nq;
    if (issue && bus.ID_class == 2'd1 && bus.ID_ValidReg[0] && bus.ID_rd != 0)
      ld_q.push_back('{rd: int'(bus.ID_rd), stage: 1});
    if (bus.div_done) m_pend = 0;
    if (issue && bus.ID_class == 2'd2 && bus.ID_rd != 0) begin
      m_pend = 1;
      m_rd   = int'(bus.ID_rd);
    end
  endfunction

  // One cycle: check outputs mid-cycle, then clock and update the model
  task automatic step(input string tag, output bit st, output int cause);
    #2;
    model_eval();
    check_eq({tag, ".stall"},  bus.stall_id,     exp_stall);
    check_eq({tag, ".bubble"}, bus.bubble_ex,    exp_stall);
    check_eq({tag, ".busy"},   bus.div_busy,     m_pend);
    check_eq({tag, ".cause"},  bus.hazard_cause, exp_cause);
`ifdef HAZARD_PERF_EN
    check_eq({tag, ".perf_lu"}, bus.perf_loaduse_cnt, m_lu_cnt);
    check_eq({tag, ".perf_dv"}, bus.perf_div_cnt,     m_dv_cnt);
`endif
    st    = bus.stall_id;
    cause = bus.hazard_cause;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input int vr, input int cls);
    bus.ID_valid    = v;
    bus.ID_rs1      = 5'(rs1);
    bus.ID_rs2      = 5'(rs2);
    bus.ID_rd       = 5'(rd);
    bus.ID_ValidReg = 3'(vr);
    bus.ID_class    = 2'(cls);
  endtask

  // Step until the ID instruction issues; returns stall count and first cause
  task automatic wait_issue(input string tag, input int maxc, output int n, output int first_cause);
    bit st;
    int c;
    n = 0;
    first_cause = 0;
    st = 1;
    for (int i = 0; i < maxc; i++) begin
      step(tag, st, c);
      if (i == 0) first_cause = c;
      if (!st) return;
      n++;
    end
    check_eq({tag, ".issued"}, st, 0);
  endtask

  bit st;
  int cs, n, fc;

  initial begin
    n_checks = 0; n_pass = 0;
    m_pend = 0; m_rd = 0; m_lu_cnt = 0; m_dv_cnt = 0;
    rst = 1'b1;
    bus.EX_ready = 1'b1; bus.flush = 1'b0; bus.div_done = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step("rst", st, cs);
    rst = 1'b0;
    step("idle", st, cs);
    check_eq("reset.stall", bus.stall_id, 0);
    check_eq("reset.busy",  bus.div_busy, 0);

    // load then immediate use: two stall cycles
    set_id(1, 0, 0, 5, 3'b001, 1); step("lw5", st, cs);
    set_id(1, 5, 1, 6, 3'b011, 0); wait_issue("lu2", 6, n, fc);
    check_eq("lu2.cycles", n, 2);
    check_eq("lu2.cause", fc, 1);

    // one independent instruction between: one stall cycle
    set_id(1, 0, 0, 5, 3'b001, 1); step("lw5b", st, cs);
    set_id(1, 0, 0, 7, 3'b001, 0); step("add7", st, cs);
    set_id(1, 1, 5, 6, 3'b101, 0); wait_issue("lu1", 6, n, fc);
    check_eq("lu1.cycles", n, 1);
    check_eq("lu1.cause", fc, 1);

    // x0 destination and unused rs1 are not hazards
    set_id(1, 0, 0, 0, 3'b001, 1); step("lw0", st, cs);
    set_id(1, 0, 0, 6, 3'b011, 0); wait_issue("x0use", 4, n, fc);
    check_eq("x0use.cycles", n, 0);
    set_id(1, 0, 0, 5, 3'b001, 1); step("lw5c", st, cs);
    set_id(1, 5, 0, 6, 3'b001, 0); wait_issue("nouse", 4, n, fc);
    check_eq("nouse.cycles", n, 0);

    // DIV x8 then consumer: stall until div_done, issue in that cycle
    set_id(1, 1, 2, 8, 3'b111, 2); step("div8", st, cs);
    set_id(1, 8, 0, 10, 3'b011, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step("divraw", st, cs);
      if (st) n++;
      if (i == 0) fc = cs;
    end
    check_eq("divraw.cycles", n, 4);
    check_eq("divraw.cause", fc, 2);
    check_eq("divraw.busy1", bus.div_busy, 1);
    bus.div_done = 1'b1; step("divdone", st, cs);
    check_eq("divdone.issue", st, 0);
    bus.div_done = 1'b0;
    check_eq("divdone.busy0", bus.div_busy, 0);
`ifdef HAZARD_PERF_EN
    check_eq("perf.lu3", bus.perf_loaduse_cnt, 3);
    check_eq("perf.dv4", bus.perf_div_cnt, 4);
`endif

    // back-to-back DIV: structural stall, then rearm with rd=9 on done
    set_id(1, 1, 2, 8, 3'b111, 2); step("div8b", st, cs);
    set_id(1, 1, 2, 9, 3'b111, 2); step("div9", st, cs);
    check_eq("struct.stall", st, 1);
    check_eq("struct.cause", cs, 3);
    bus.div_done = 1'b1; step("div9iss", st, cs);
    check_eq("div9iss.stall", st, 0);
    bus.div_done = 1'b0;
    check_eq("div9.busy", bus.div_busy, 1);
    set_id(1, 9, 0, 11, 3'b011, 0); step("use9", st, cs);
    check_eq("use9.cause", cs, 2);
    set_id(1, 8, 0, 11, 3'b011, 0); step("use8", st, cs);
    check_eq("use8.stall", st, 0);

    // reset during a divider stall clears everything
    set_id(1, 9, 0, 11, 3'b011, 0); rst = 1'b1; step("rstdiv", st, cs);
    rst = 1'b0; step("postrst", st, cs);
    check_eq("postrst.stall", st, 0);
    check_eq("postrst.busy", bus.div_busy, 0);

    // flushed load never enters EX
    set_id(1, 0, 0, 5, 3'b001, 1); bus.flush = 1'b1; step("lwflush", st, cs);
    check_eq("lwflush.stall", st, 0);
    bus.flush = 1'b0;
    set_id(1, 5, 0, 6, 3'b011, 0); wait_issue("flushuse", 4, n, fc);
    check_eq("flushuse.cycles", n, 0);

    // randomized traffic; stalled instructions are held in ID
    st = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.EX_ready = ($urandom_range(0, 7) != 0);
      bus.div_done = m_pend && ($urandom_range(0, 3) == 0);
      if (!st || bus.flush) begin
        set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      end
      bus.flush = ($urandom_range(0, 11) == 0);
      step("rand", st, cs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
